// File: rtl/xain_pkg.sv
// Shared types and default widths for the SDRAM ROM request arbiter.
package xain_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    localparam int unsigned SDR_AW = 25;
    localparam int unsigned SDR_DW = 16;

endpackage

// File: rtl/sdr_rom_arbiter_rr_pick.sv
// Combinational round-robin select: the first set request at or after ptr_i, wrapping at N.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          any_o
);

    // ptr_i + offset is below 2*N, so one conditional subtract wraps it for any N.
    function automatic logic [IW-1:0] wrap(input logic [IW:0] a);
        logic [IW:0] r;
        r = (a >= (IW + 1)'(N)) ? a - (IW + 1)'(N) : a;
        return r[IW-1:0];
    endfunction

    // Walk rotated offsets from highest to lowest so the lowest requesting offset wins.
    always_comb begin
        logic [IW-1:0] idx;
        grant_o = '0;
        any_o   = 1'b0;
        for (int unsigned k = N; k > 0; k--) begin
            idx = wrap({1'b0, ptr_i} + (IW + 1)'(k - 1));
            if (req_i[idx]) begin
                grant_o = idx;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdr_rom_arbiter.sv
// Round-robin arbiter collecting client ROM reads and issuing one SDRAM read at a time.
module sdr_rom_arbiter
    import xain_pkg::*;
#(
    parameter int unsigned NCLI    = 4,
    parameter int unsigned AW      = SDR_AW,
    parameter int unsigned DW      = SDR_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk_ram_i,
    input  logic                 reset_i,
    input  logic [NCLI-1:0]      cli_req_i,
    input  logic [NCLI*AW-1:0]   cli_addr_i,
    output logic [NCLI-1:0]      cli_rdy_o,
    output logic [NCLI*DW-1:0]   cli_data_o,
    output logic [AW-1:0]        ctl_addr_o,
    output logic                 ctl_rd_o,
    input  logic                 ctl_valid_i,
    input  logic [DW-1:0]        ctl_dout_i,
    output logic [7:0]           retry_cnt_o
);

    localparam int unsigned IW      = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam logic [7:0]  TmoLast = 8'(TIMEOUT);

    arb_state_t      state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   g_q;
    logic [NCLI-1:0] cli_rdy_q;
    logic [DW-1:0]   data_q [NCLI];
    logic [AW-1:0]   ctl_addr_q;
    logic            ctl_rd_q;
    logic [7:0]      retry_cnt_q;
    logic [7:0]      tmo_q;

    logic [AW-1:0]   addr_arr [NCLI];
    logic [IW-1:0]   pick;
    logic            pick_any;

    for (genvar i = 0; i < NCLI; i++) begin : g_unpack
        assign addr_arr[i]              = cli_addr_i[i*AW +: AW];
        assign cli_data_o[i*DW +: DW]   = data_q[i];
    end

    rr_pick #(
        .N (NCLI)
    ) u_rr_pick (
        .req_i   (cli_req_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick),
        .any_o   (pick_any)
    );

    // Arbiter FSM with all outputs registered; ctl_rd is high exactly while in ARB_ISSUE.
    always_ff @(posedge clk_ram_i) begin
        if (reset_i) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            g_q         <= '0;
            cli_rdy_q   <= '0;
            ctl_addr_q  <= '0;
            ctl_rd_q    <= 1'b0;
            retry_cnt_q <= '0;
            tmo_q       <= '0;
            for (int i = 0; i < NCLI; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        g_q        <= pick;
                        ctl_addr_q <= addr_arr[pick];
                        ctl_rd_q   <= 1'b1;
                        state_q    <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    ctl_rd_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    tmo_q <= tmo_q + 8'd1;
                    // Data beats the timeout when both land in the same cycle.
                    if (ctl_valid_i) begin
                        data_q[g_q]    <= ctl_dout_i;
                        cli_rdy_q[g_q] <= 1'b1;
                        state_q        <= ARB_DONE;
                    end else if (tmo_q == TmoLast) begin
                        if (retry_cnt_q != 8'hFF) begin
                            retry_cnt_q <= retry_cnt_q + 8'd1;
                        end
                        ctl_rd_q <= 1'b1;
                        state_q  <= ARB_ISSUE;
                    end
                end
                ARB_DONE: begin
                    cli_rdy_q <= '0;
                    if (g_q == IW'(NCLI - 1)) begin
                        rr_ptr_q <= '0;
                    end else begin
                        rr_ptr_q <= g_q + 1'b1;
                    end
                    state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign cli_rdy_o   = cli_rdy_q;
    assign ctl_addr_o  = ctl_addr_q;
    assign ctl_rd_o    = ctl_rd_q;
    assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_sdr_rom_arbiter.sv
// Bench for sdr_rom_arbiter: a 4-client instance and a 3-client instance on one clock.
module tb_sdr_rom_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [3:0]      req_a;
    logic [4*AW-1:0] addr_a;
    logic [3:0]      rdy_a;
    logic [4*DW-1:0] data_a;
    logic [AW-1:0]   caddr_a;
    logic            rd_a;
    logic            valid_a;
    logic [DW-1:0]   dout_a;
    logic [7:0]      retry_a;

    logic [2:0]      req_b;
    logic [3*AW-1:0] addr_b;
    logic [2:0]      rdy_b;
    logic [3*DW-1:0] data_b;
    logic [AW-1:0]   caddr_b;
    logic            rd_b;
    logic            valid_b;
    logic [DW-1:0]   dout_b;
    logic [7:0]      retry_b;

    sdr_rom_arbiter #(.NCLI(4), .AW(AW), .DW(DW), .TIMEOUT(255)) u_dut_a (
        .clk_ram_i   (clk),
        .reset_i     (rst),
        .cli_req_i   (req_a),
        .cli_addr_i  (addr_a),
        .cli_rdy_o   (rdy_a),
        .cli_data_o  (data_a),
        .ctl_addr_o  (caddr_a),
        .ctl_rd_o    (rd_a),
        .ctl_valid_i (valid_a),
        .ctl_dout_i  (dout_a),
        .retry_cnt_o (retry_a)
    );

    sdr_rom_arbiter #(.NCLI(3), .AW(AW), .DW(DW), .TIMEOUT(255)) u_dut_b (
        .clk_ram_i   (clk),
        .reset_i     (rst),
        .cli_req_i   (req_b),
        .cli_addr_i  (addr_b),
        .cli_rdy_o   (rdy_b),
        .cli_data_o  (data_b),
        .ctl_addr_o  (caddr_b),
        .ctl_rd_o    (rd_b),
        .ctl_valid_i (valid_b),
        .ctl_dout_i  (dout_b),
        .retry_cnt_o (retry_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: next round-robin start and last word delivered per client.
    int            ptr_a, ptr_b;
    logic [DW-1:0] exp_a [4];
    logic [DW-1:0] exp_b [3];

    function automatic int model_pick(input logic [3:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [4*DW-1:0] pack_a();
        logic [4*DW-1:0] r;
        for (int i = 0; i < 4; i++) r[i*DW +: DW] = exp_a[i];
        return r;
    endfunction

    function automatic logic [3*DW-1:0] pack_b();
        logic [3*DW-1:0] r;
        for (int i = 0; i < 3; i++) r[i*DW +: DW] = exp_b[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ptr_a = 0;
        ptr_b = 0;
        for (int i = 0; i < 4; i++) exp_a[i] = '0;
        for (int i = 0; i < 3; i++) exp_b[i] = '0;
    endtask

    // One full transaction on instance A: grant, optional stray/mid-flight events, data return.
    task automatic serve_a(input int c, input int lat, input logic [DW-1:0] d,
                           input bit drop, input bit mid, input bit stray);
        logic [AW-1:0] ea;
        int n;
        ea = addr_a[c*AW +: AW];
        n = 0;
        while (rd_a !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (rd_a !== 1'b1 || n != 1) begin
            miscompares++;
            $display("FAIL rd_latency_a: ctl_rd=%b after %0d cycles, required 1 after 1", rd_a, n);
        end
        vectors++;
        if (caddr_a !== ea) begin
            miscompares++;
            $display("FAIL grant_addr_a client %0d: ctl_addr=%h, required %h", c, caddr_a, ea);
        end
        if (stray) begin
            valid_a = 1'b1;
            dout_a  = ~d;
        end
        step();
        valid_a = 1'b0;
        vectors++;
        if (rd_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_pulse_a: ctl_rd=%b one cycle after strobe, required 0", rd_a);
        end
        if (mid) begin
            req_a[c] = 1'($urandom_range(0, 1));
            addr_a[c*AW +: AW] = AW'($urandom);
        end
        repeat (lat - 1) step();
        valid_a = 1'b1;
        dout_a  = d;
        step();
        valid_a = 1'b0;
        exp_a[c] = d;
        ptr_a = (c + 1) % 4;
        vectors++;
        if (rdy_a !== 4'(1 << c)) begin
            miscompares++;
            $display("FAIL rdy_a client %0d: cli_rdy=%b, required %b", c, rdy_a, 4'(1 << c));
        end
        vectors++;
        if (data_a !== pack_a()) begin
            miscompares++;
            $display("FAIL data_a client %0d: cli_data=%h, required %h", c, data_a, pack_a());
        end
        if (drop) req_a[c] = 1'b0;
        step();
        vectors++;
        if (rdy_a !== 4'b0) begin
            miscompares++;
            $display("FAIL rdy_pulse_a: cli_rdy=%b after pulse, required 0000", rdy_a);
        end
    endtask

    task automatic serve_b(input int c, input int lat, input logic [DW-1:0] d);
        logic [AW-1:0] ea;
        int n;
        ea = addr_b[c*AW +: AW];
        n = 0;
        while (rd_b !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (rd_b !== 1'b1 || caddr_b !== ea) begin
            miscompares++;
            $display("FAIL grant_b client %0d: ctl_rd=%b ctl_addr=%h, required 1 %h",
                     c, rd_b, caddr_b, ea);
        end
        repeat (lat) step();
        valid_b = 1'b1;
        dout_b  = d;
        step();
        valid_b = 1'b0;
        exp_b[c] = d;
        ptr_b = (c + 1) % 3;
        vectors++;
        if (rdy_b !== 3'(1 << c) || data_b !== pack_b()) begin
            miscompares++;
            $display("FAIL rdy_b client %0d: cli_rdy=%b cli_data=%h, required %b %h",
                     c, rdy_b, data_b, 3'(1 << c), pack_b());
        end
        req_b[c] = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        step();
        vectors++;
        if ({rdy_a, data_a, caddr_a, rd_a, retry_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: rdy=%b data=%h addr=%h rd=%b retry=%0d, required all zero",
                     rdy_a, data_a, caddr_a, rd_a, retry_a);
        end
        vectors++;
        if ({rdy_b, data_b, caddr_b, rd_b, retry_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: rdy=%b data=%h addr=%h rd=%b retry=%0d, required all zero",
                     rdy_b, data_b, caddr_b, rd_b, retry_b);
        end
    endtask

    task automatic test_single();
        do_reset();
        addr_a[0 +: AW] = 25'h1234;
        req_a = 4'b0001;
        serve_a(0, 3, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        int c;
        do_reset();
        for (int i = 0; i < 4; i++) addr_a[i*AW +: AW] = AW'($urandom);
        req_a = 4'hF;
        for (int t = 0; t < 5; t++) begin
            c = model_pick(req_a, ptr_a, 4);
            serve_a(c, $urandom_range(1, 5), DW'($urandom), 1'b0, 1'b0, 1'b0);
        end
        req_a = '0;
        step();
    endtask

    task automatic test_retry();
        logic [AW-1:0] ea;
        bit            extra;
        int            n;
        do_reset();
        ea = AW'($urandom);
        addr_a[2*AW +: AW] = ea;
        req_a = 4'b0100;
        step();
        n = 0;
        step();
        n++;
        while (rd_a !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        vectors++;
        if (rd_a !== 1'b1 || n != 257) begin
            miscompares++;
            $display("FAIL retry_reissue: ctl_rd=%b after %0d cycles, required 1 after 257", rd_a, n);
        end
        vectors++;
        if (caddr_a !== ea || retry_a !== 8'd1) begin
            miscompares++;
            $display("FAIL retry_state: ctl_addr=%h retry_cnt=%0d, required %h 1", caddr_a, retry_a, ea);
        end
        repeat (5) step();
        valid_a = 1'b1;
        dout_a  = 16'h5A5A;
        step();
        valid_a = 1'b0;
        exp_a[2] = 16'h5A5A;
        ptr_a = 3;
        vectors++;
        if (rdy_a !== 4'b0100 || data_a !== pack_a()) begin
            miscompares++;
            $display("FAIL retry_deliver: cli_rdy=%b cli_data=%h, required 0100 %h",
                     rdy_a, data_a, pack_a());
        end
        req_a = '0;
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rdy_a !== 4'b0 || rd_a !== 1'b0) extra = 1'b1;
        end
        vectors++;
        if (extra || retry_a !== 8'd1) begin
            miscompares++;
            $display("FAIL retry_quiet: extra activity=%b retry_cnt=%0d, required 0 1", extra, retry_a);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        addr_a[1*AW +: AW] = AW'($urandom);
        req_a = 4'b0010;
        serve_a(1, 2, 16'h1111, 1'b1, 1'b0, 1'b0);
        req_a = 4'b0010;
        step();
        step();
        step();
        rst = 1'b1;
        req_a = '0;
        step();
        rst = 1'b0;
        ptr_a = 0;
        for (int i = 0; i < 4; i++) exp_a[i] = '0;
        vectors++;
        if ({rdy_a, data_a, caddr_a, rd_a, retry_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: rdy=%b data=%h addr=%h rd=%b retry=%0d, required all zero",
                     rdy_a, data_a, caddr_a, rd_a, retry_a);
        end
        valid_a = 1'b1;
        dout_a  = 16'hDEAD;
        step();
        valid_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rdy_a !== 4'b0 || rd_a !== 1'b0 || data_a !== '0) seen = 1'b1;
            step();
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL late_valid: activity after reset=%b, required 0", seen);
        end
        addr_a[3*AW +: AW] = AW'($urandom);
        req_a = 4'b1000;
        serve_a(3, 1, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_valid_at_timeout();
        do_reset();
        addr_a[3*AW +: AW] = AW'($urandom);
        req_a = 4'b1000;
        serve_a(3, 256, 16'hC0DE, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (retry_a !== 8'd0) begin
            miscompares++;
            $display("FAIL timeout_tie: retry_cnt=%0d, required 0", retry_a);
        end
    endtask

    task automatic test_random();
        int c;
        do_reset();
        req_a = '0;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_a[i] && $urandom_range(0, 1) == 1) begin
                    req_a[i] = 1'b1;
                    addr_a[i*AW +: AW] = AW'($urandom);
                end
            end
            if (req_a == 4'b0) begin
                c = $urandom_range(0, 3);
                req_a[c] = 1'b1;
                addr_a[c*AW +: AW] = AW'($urandom);
            end
            c = model_pick(req_a, ptr_a, 4);
            serve_a(c, $urandom_range(1, 8), DW'($urandom), 1'b1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        req_a = '0;
        step();
    endtask

    task automatic test_ncli3();
        int c;
        do_reset();
        for (int i = 0; i < 3; i++) addr_b[i*AW +: AW] = AW'($urandom);
        req_b = 3'b010;
        serve_b(1, 2, DW'($urandom));
        req_b = 3'b110;
        for (int t = 0; t < 2; t++) begin
            c = model_pick({1'b0, req_b}, ptr_b, 3);
            serve_b(c, $urandom_range(1, 4), DW'($urandom));
        end
        req_b = 3'b101;
        for (int t = 0; t < 2; t++) begin
            c = model_pick({1'b0, req_b}, ptr_b, 3);
            serve_b(c, $urandom_range(1, 4), DW'($urandom));
        end
    endtask

    // Never more than one ready pulse per cycle on either instance.
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if ($countones(rdy_a) > 1 || $countones(rdy_b) > 1) begin
                miscompares++;
                $display("FAIL rdy_onehot: cli_rdy_a=%b cli_rdy_b=%b, required at most one bit",
                         rdy_a, rdy_b);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        req_a   = '0;
        addr_a  = '0;
        valid_a = 1'b0;
        dout_a  = '0;
        req_b   = '0;
        addr_b  = '0;
        valid_b = 1'b0;
        dout_b  = '0;
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_retry();
        test_reset_mid();
        test_valid_at_timeout();
        test_random();
        test_ncli3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
